// File: rtl/bmi_pkg.sv
// Shared definitions for the BMI engine and the downstream category comparator.
// Holds the FSM state encoding, arithmetic constants and the category thresholds.
// Both stages use this package, so the thresholds are defined in one place only.
package bmi_pkg;

    localparam int W_WIDTH      = 8;
    localparam int H_WIDTH      = 8;
    localparam int BMI_WIDTH    = 8;
    localparam int SCALE        = 10000;
    localparam int DIV_BITS     = 22;     // holds 255 * 10000
    localparam int DIVISOR_BITS = 2 * H_WIDTH;

    localparam logic [BMI_WIDTH-1:0] BMI_MAX = 8'hFF;

    // Category thresholds on the integer (truncated) BMI
    localparam logic [BMI_WIDTH-1:0] UNDERWEIGHT_MAX = 8'd18;
    localparam logic [BMI_WIDTH-1:0] NORMAL_MAX      = 8'd24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAT_UNDERWEIGHT = 2'd0,
        CAT_NORMAL      = 2'd1,
        CAT_OVERWEIGHT  = 2'd2
    } category_t;

    function automatic category_t bmi_category(input logic [BMI_WIDTH-1:0] bmi);
        if (bmi <= UNDERWEIGHT_MAX)
            return CAT_UNDERWEIGHT;
        else if (bmi <= NORMAL_MAX)
            return CAT_NORMAL;
        else
            return CAT_OVERWEIGHT;
    endfunction

endpackage

// File: rtl/bmi_calculator_seq_divider.sv
// Restoring divider, one quotient bit per clock.
// Ports:
//   clk, srst  : clock and synchronous active-high reset
//   load       : capture dividend/divisor, clear remainder/quotient, start
//   dividend   : unsigned dividend, DIVIDEND_W bits
//   divisor    : unsigned divisor, DIVISOR_W bits
//   busy       : division steps in progress
//   ready      : the step on this edge is the final one; quotient is complete after it
//   quotient   : result, held until the next load
// A zero divisor is not special-cased here: every step subtracts nothing and
// shifts in a 1. The caller flags that case itself.
module seq_divider #(
    parameter int DIVIDEND_W = 22,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  ready,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVIDEND_W-1:0] dividend_reg;
    logic [DIVISOR_W-1:0]  divisor_reg;
    logic [DIVISOR_W:0]    rem_reg;
    logic [DIVIDEND_W-1:0] quot_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  busy_reg;

    logic [DIVISOR_W:0]    rem_shift;
    logic [DIVISOR_W:0]    rem_next;
    logic                  fits;

    // Remainder stays below the divisor, so its low DIVISOR_W bits carry it
    always_comb begin
        rem_shift = {rem_reg[DIVISOR_W-1:0], dividend_reg[DIVIDEND_W-1]};
        fits      = (rem_shift >= {1'b0, divisor_reg});
        rem_next  = fits ? (rem_shift - {1'b0, divisor_reg}) : rem_shift;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
        end else if (load) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= CNT_W'(DIVIDEND_W - 1);
            busy_reg     <= 1'b1;
        end else if (busy_reg) begin
            dividend_reg <= {dividend_reg[DIVIDEND_W-2:0], 1'b0};
            rem_reg      <= rem_next;
            quot_reg     <= {quot_reg[DIVIDEND_W-2:0], fits};
            if (cnt_reg == '0)
                busy_reg <= 1'b0;
            else
                cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign busy     = busy_reg;
    assign ready    = busy_reg && (cnt_reg == '0);
    assign quotient = quot_reg;

endmodule

// File: rtl/bmi_calculator.sv
// Sequential BMI engine: bmi = floor(weight*10000 / height^2), saturating at 255.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   start      : request, honoured only in IDLE
//   weight     : kg, captured when start is accepted
//   height     : cm, captured when start is accepted
//   busy       : high from LOAD through DONE
//   done       : one-cycle pulse when bmi/sat/div_err are updated
//   bmi        : result, held until the next done
//   sat        : quotient exceeded 255, bmi forced to 255
//   div_err    : height was zero, bmi forced to 255
// Fixed latency: done appears 24 clocks after the accepting edge
// (1 LOAD + 22 DIV + 1 DONE), including the height==0 case.
module bmi_calculator
    import bmi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W_WIDTH-1:0]   weight,
    input  logic [H_WIDTH-1:0]   height,
    output logic                 busy,
    output logic                 done,
    output logic [BMI_WIDTH-1:0] bmi,
    output logic                 sat,
    output logic                 div_err
);

    localparam logic [DIV_BITS-1:0] SCALE_V = DIV_BITS'(SCALE);

    state_t                state_reg;
    logic [W_WIDTH-1:0]    weight_reg;
    logic [H_WIDTH-1:0]    height_reg;
    logic                  zero_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [BMI_WIDTH-1:0]  bmi_reg;
    logic                  sat_reg;
    logic                  div_err_reg;

    logic                  div_load;
    logic                  div_busy;
    logic                  div_ready;
    logic [DIV_BITS-1:0]   div_dividend;
    logic [DIVISOR_BITS-1:0] div_divisor;
    logic [DIV_BITS-1:0]   div_quotient;

    // Operands are formed from the captured inputs, so input changes after
    // the accepting edge cannot reach the divider.
    assign div_load     = (state_reg == LOAD);
    assign div_dividend = DIV_BITS'(weight_reg) * SCALE_V;
    assign div_divisor  = DIVISOR_BITS'(height_reg) * DIVISOR_BITS'(height_reg);

    seq_divider #(
        .DIVIDEND_W(DIV_BITS),
        .DIVISOR_W (DIVISOR_BITS)
    ) u_div (
        .clk      (clk),
        .srst     (rst),
        .load     (div_load),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .ready    (div_ready),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            weight_reg  <= '0;
            height_reg  <= '0;
            zero_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            bmi_reg     <= '0;
            sat_reg     <= 1'b0;
            div_err_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        weight_reg <= weight;
                        height_reg <= height;
                        busy_reg   <= 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    zero_reg  <= (height_reg == '0);
                    state_reg <= DIV;
                end
                DIV: begin
                    if (div_busy && div_ready)
                        state_reg <= DONE;
                end
                DONE: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    if (zero_reg) begin
                        bmi_reg     <= BMI_MAX;
                        sat_reg     <= 1'b0;
                        div_err_reg <= 1'b1;
                    end else if (|div_quotient[DIV_BITS-1:BMI_WIDTH]) begin
                        bmi_reg     <= BMI_MAX;
                        sat_reg     <= 1'b1;
                        div_err_reg <= 1'b0;
                    end else begin
                        bmi_reg     <= div_quotient[BMI_WIDTH-1:0];
                        sat_reg     <= 1'b0;
                        div_err_reg <= 1'b0;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bmi     = bmi_reg;
    assign sat     = sat_reg;
    assign div_err = div_err_reg;

endmodule

// File: tb/tb_bmi_calculator.sv
module tb_bmi_calculator;
    import bmi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] weight;
    logic [7:0] height;
    logic       busy;
    logic       done;
    logic [7:0] bmi;
    logic       sat;
    logic       div_err;

    int total = 0;
    int bad   = 0;

    bmi_calculator dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .weight  (weight),
        .height  (height),
        .busy    (busy),
        .done    (done),
        .bmi     (bmi),
        .sat     (sat),
        .div_err (div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
        $display("check %-14s got=%0d exp=%0d", tag, obs, exp);
    endtask

    // Drive inputs at a negedge and return just after the accepting edge.
    task automatic start_op(input logic [7:0] w, input logic [7:0] h);
        weight = w;
        height = h;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Number of clocks until done is seen, or 0 if it never comes within budget.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [7:0] w, input logic [7:0] h,
                             input int exp_bmi, input int exp_sat, input int exp_err);
        int lat;
        start_op(w, h);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 24);
        chk({tag, "_bmi"}, bmi, exp_bmi);
        chk({tag, "_sat"}, sat, exp_sat);
        chk({tag, "_err"}, div_err, exp_err);
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; start = 1'b0; weight = '0; height = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bmi", bmi, 0);
        chk("rst_sat", sat, 0);
        chk("rst_err", div_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // 70 kg, 175 cm: 700000/30625 = 22.86
        start_op(8'd70, 8'd175);
        chk("busy_after_acc", busy, 1);
        wait_done(lat);
        chk("base_lat", lat, 24);
        chk("base_bmi", bmi, 22);
        chk("base_sat", sat, 0);
        chk("base_err", div_err, 0);
        chk("base_busy_done", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("bmi_hold", bmi, 22);

        // Back-to-back with start held: 40/170 -> 13, then 120/160 -> 46
        weight = 8'd40; height = 8'd170; start = 1'b1;
        @(negedge clk);
        weight = 8'd120; height = 8'd160;
        wait_done(lat);
        chk("b2b1_lat", lat, 24);
        chk("b2b1_bmi", bmi, 13);
        wait_done(lat);
        chk("b2b2_lat", lat, 25);
        chk("b2b2_bmi", bmi, 46);
        start = 1'b0;
        @(negedge clk);

        // 255/50: quotient 1020 saturates
        run_check("sat", 8'd255, 8'd50, 255, 1, 0);
        chk("cat_sat", bmi_category(bmi), CAT_OVERWEIGHT);

        // Zero height, then zero weight
        run_check("h0", 8'd80, 8'd0, 255, 0, 1);
        run_check("w0", 8'd0, 8'd100, 0, 0, 0);

        // Comparator chain: 37/175 -> 12, 71/175 -> 23
        run_check("c12", 8'd37, 8'd175, 12, 0, 0);
        chk("cat_12", bmi_category(bmi), CAT_UNDERWEIGHT);
        run_check("c23", 8'd71, 8'd175, 23, 0, 0);
        chk("cat_23", bmi_category(bmi), CAT_NORMAL);

        // Start pulse mid-DIV with changed operands is ignored
        start_op(8'd70, 8'd175);
        repeat (8) @(negedge clk);
        weight = 8'd10; height = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("mid_lat", lat, 15);
        chk("mid_bmi", bmi, 22);
        repeat (3) @(negedge clk);
        chk("mid_no_relaunch", busy, 0);

        // Reset at DIV cycle 10 aborts without done
        start_op(8'd70, 8'd175);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_bmi", bmi, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_check("post_abort", 8'd70, 8'd175, 22, 0, 0);

        // rst and start together: rst wins
        rst = 1'b1; weight = 8'd70; height = 8'd175; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_bmi", bmi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
